// File: rtl/machine_state_dumper_if.sv
`default_nettype none
// ============================================================================
// machine_state_dumper_if : state-dump port bundle (machine side + out stream)
// Rev 1.0
// ============================================================================
interface machine_state_dumper_if;
   logic        halt;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic [31:0] mem_addr;
   logic [7:0]  mem_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_tag;
   logic [4:0]  out_index;
   logic        busy;
   logic        done;
   logic        timed_out;

   modport master (
      input  halt, rf_data, mem_data, out_ready,
      output rf_addr, mem_addr, out_valid, out_data, out_tag, out_index,
             busy, done, timed_out
   );

   modport slave (
      output halt, rf_data, mem_data, out_ready,
      input  rf_addr, mem_addr, out_valid, out_data, out_tag, out_index,
             busy, done, timed_out
   );
endinterface
`default_nettype wire

// File: rtl/machine_state_dumper.sv
`default_nettype none
// ============================================================================
// machine_state_dumper : on halt (or watchdog, DUMPER_WATCHDOG_EN) streams
// r0..r31 then MEM_BYTES data-memory bytes on a valid/ready port.
// Rev 1.0
// ============================================================================
module machine_state_dumper #(
   parameter logic [31:0] MEM_BASE  = 32'h4000,
   parameter int          MEM_BYTES = 4,
   parameter int          TIMEOUT   = 64
) (
   input  wire logic              clk,
   input  wire logic              reset,
   machine_state_dumper_if.master dif
);
   localparam logic [5:0] c_LAST = 6'(31 + MEM_BYTES);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [5:0]  r_e;
   logic        r_valid;
   logic [31:0] r_data;
   logic        r_tag;
   logic [4:0]  r_index;
   logic        w_trigger;
   logic        w_capture;
   logic        w_accept;
   logic        w_wd_fire;
   logic        w_is_mem;

   // Element index >= 32 selects memory; its low 5 bits are then the byte offset.
   assign w_is_mem     = r_e[5];
   assign dif.rf_addr  = w_is_mem ? 5'd0 : r_e[4:0];
   assign dif.mem_addr = MEM_BASE + (w_is_mem ? {27'd0, r_e[4:0]} : 32'd0);

   assign dif.out_valid = r_valid;
   assign dif.out_data  = r_data;
   assign dif.out_tag   = r_tag;
   assign dif.out_index = r_index;
   assign dif.busy      = (r_state == S_FETCH) || (r_state == S_HOLD);
   assign dif.done      = (r_state == S_DONE);

`ifdef DUMPER_WATCHDOG_EN
   logic [31:0] r_cnt;
   logic        r_timed_out;

   assign w_wd_fire     = (r_state == S_RUN) && (r_cnt == 32'(TIMEOUT - 1));
   assign dif.timed_out = r_timed_out;

   // Counter freezes at the firing value and never advances outside RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt       <= 32'd0;
         r_timed_out <= 1'b0;
      end else begin
         if ((r_state == S_RUN) && !w_wd_fire) begin
            r_cnt <= r_cnt + 32'd1;
         end
         if (w_wd_fire && !dif.halt) begin
            r_timed_out <= 1'b1;
         end
      end
   end
`else
   logic w_unused_timeout;

   assign w_wd_fire        = 1'b0;
   assign dif.timed_out    = 1'b0;
   assign w_unused_timeout = ^TIMEOUT;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_trigger   = 1'b0;
      w_capture   = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_RUN: begin
            if (dif.halt || w_wd_fire) begin
               w_trigger   = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (r_valid && dif.out_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = (r_e == c_LAST) ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            w_state_nxt = S_DONE;
         end
         default: begin
            w_state_nxt = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_e     <= 6'd0;
         r_valid <= 1'b0;
         r_data  <= 32'd0;
         r_tag   <= 1'b0;
         r_index <= 5'd0;
      end else begin
         if (w_trigger) begin
            r_e <= 6'd0;
         end else if (w_accept && (r_e != c_LAST)) begin
            r_e <= r_e + 6'd1;
         end

         if (w_capture) begin
            r_valid <= 1'b1;
            r_data  <= w_is_mem ? {24'd0, dif.mem_data} : dif.rf_data;
            r_tag   <= w_is_mem;
            r_index <= r_e[4:0];
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
      end
   end
endmodule
`default_nettype wire
